// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, node count and arbiter state encoding.
package noc_pkg;

  localparam int unsigned FLIT_W    = 11;
  localparam int unsigned IP_W      = 4;
  localparam int unsigned NUM_NODES = 16;

  // Destination node address sits in the top bits of every flit.
  localparam int unsigned DEST_LSB = 7;
  localparam int unsigned DEST_MSB = DEST_LSB + IP_W - 1;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic logic [IP_W-1:0] flit_dest(input logic [FLIT_W-1:0] flit);
    return flit[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/noc_port_arbiter_if.sv
// Requester-side and link-side signals of one router output port.
interface noc_port_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned FLIT_W = 11,
  parameter int unsigned IDX_W  = 2
);

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][FLIT_W-1:0] req_data;
  logic [N_REQ-1:0]             req_tail;
  logic [N_REQ-1:0]             req_enable;
  logic [N_REQ-1:0]             req_ready;
  logic                         out_valid;
  logic [FLIT_W-1:0]            out_data;
  logic                         out_tail;
  logic                         out_ready;
  logic [IDX_W-1:0]             grant_idx;
  logic                         locked;

  modport master (
    output req_valid, req_data, req_tail, req_enable, out_ready,
    input  req_ready, out_valid, out_data, out_tail, grant_idx, locked
  );

  modport slave (
    input  req_valid, req_data, req_tail, req_enable, out_ready,
    output req_ready, out_valid, out_data, out_tail, grant_idx, locked
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned off = 0; off < N; off++) begin
      pos = 32'(ptr_i) + off;
      if (pos >= N) pos = pos - N;
      pos_idx = IDX_W'(pos);
      if (!any_o && req_i[pos_idx]) begin
        any_o          = 1'b1;
        idx_o          = pos_idx;
        gnt_o[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_port_arbiter.sv
// Output-port arbiter: round-robin between requesters, locked per packet, one-entry output reg.
module noc_port_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned FLIT_W = noc_pkg::FLIT_W,
  parameter int unsigned IDX_W  = 2
) (
  input logic CLK,
  input logic RESET,
  noc_port_arbiter_if.slave link
);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_data_q, out_data_d;
  logic              out_tail_q, out_tail_d;

  logic              slot_free;
  logic [N_REQ-1:0]  cand;
  logic [N_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              load;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_tail;
  logic [N_REQ-1:0]  req_ready;

  // The register can take a new flit whenever it is empty or draining this cycle.
  assign slot_free = !out_valid_q || link.out_ready;
  assign cand      = link.req_valid & link.req_enable;
  assign sel_tail  = link.req_tail[sel_idx];

  rr_picker #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req_i (cand),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      if (sel_tail) begin
        state_d  = ARB;
        rr_ptr_d = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
      end else begin
        state_d = LOCKED;
      end
    end
  end

  // While locked the owner is served regardless of its enable so packets always complete.
  always_comb begin
    load      = 1'b0;
    sel_idx   = grant_idx_q;
    req_ready = '0;
    if (!RESET) begin
      unique case (state_q)
        ARB: begin
          if (slot_free && pick_any) begin
            load      = 1'b1;
            sel_idx   = pick_idx;
            req_ready = pick_gnt;
          end
        end
        LOCKED: begin
          if (slot_free && link.req_valid[grant_idx_q]) begin
            load                   = 1'b1;
            req_ready[grant_idx_q] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tail_d  = out_tail_q;
    grant_idx_d = grant_idx_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = link.req_data[sel_idx];
      out_tail_d  = sel_tail;
      grant_idx_d = sel_idx;
    end else if (link.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tail_q  <= 1'b0;
      grant_idx_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tail_q  <= out_tail_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign link.req_ready = req_ready;
  assign link.out_valid = out_valid_q;
  assign link.out_data  = out_data_q;
  assign link.out_tail  = out_tail_q;
  assign link.grant_idx = grant_idx_q;
  assign link.locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Bench for noc_port_arbiter: directed scenarios plus random traffic against a packet-level model.
module tb_noc_port_arbiter;

  localparam int N  = 4;
  localparam int FW = 11;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_port_arbiter_if #(.N_REQ(N), .FLIT_W(FW), .IDX_W(IW)) link ();

  noc_port_arbiter #(
    .N_REQ  (N),
    .FLIT_W (FW),
    .IDX_W  (IW)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .link  (link)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Sources: remaining flits of the current packet (0 = idle) and packet length to restart with.
  int          src_len[N];
  int          src_refill[N];
  logic [FW-1:0] src_data[N];
  logic [N-1:0] en;
  bit          oready;

  // Model: output register, owner, lock flag, round-robin pointer.
  bit          m_init = 0;
  bit          m_ov, m_ot, m_lock;
  logic [FW-1:0] m_od;
  int          m_rr, m_grant, m_sel;
  int          hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      link.req_valid[i] = (src_len[i] > 0);
      link.req_tail[i]  = (src_len[i] == 1);
      link.req_data[i]  = src_data[i];
    end
    link.req_enable = en;
    link.out_ready  = oready;
  endtask

  task automatic cycle();
    logic [N-1:0] exp_ready;
    bit slot, tail;
    drive();
    @(negedge clk);
    m_sel     = -1;
    exp_ready = '0;
    slot      = !m_ov || oready;
    if (!rst && slot) begin
      if (m_lock) begin
        if (src_len[m_grant] > 0) m_sel = m_grant;
      end else begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_rr + k) % N;
          if (m_sel < 0 && src_len[i] > 0 && en[i]) m_sel = i;
        end
      end
    end
    if (m_sel >= 0) exp_ready[m_sel] = 1'b1;
    chk("req_ready", link.req_ready, exp_ready);
    if (m_init) begin
      chk("out_valid", link.out_valid, m_ov);
      chk("out_data", link.out_data, m_od);
      chk("out_tail", link.out_tail, m_ot);
      chk("grant_idx", link.grant_idx, m_grant);
      chk("locked", link.locked, m_lock);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_init = 1; m_ov = 0; m_od = '0; m_ot = 0; m_lock = 0; m_rr = 0; m_grant = 0;
    end else if (m_sel >= 0) begin
      tail    = (src_len[m_sel] == 1);
      m_ov    = 1;
      m_od    = src_data[m_sel];
      m_ot    = tail;
      m_grant = m_sel;
      hist.push_back(m_sel);
      if (tail) begin
        m_lock = 0;
        m_rr   = (m_sel + 1) % N;
      end else begin
        m_lock = 1;
      end
      src_len[m_sel]--;
      src_data[m_sel] = FW'($urandom);
      if (src_len[m_sel] == 0) src_len[m_sel] = src_refill[m_sel];
    end else if (oready) begin
      m_ov = 0;
    end
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_len[i]    = 0;
      src_refill[i] = 0;
    end
    repeat (n) cycle();
    rst = 1'b0;
    hist.delete();
  endtask

  task automatic start_singles(input logic [N-1:0] which);
    for (int i = 0; i < N; i++) begin
      if (which[i]) begin
        src_len[i]    = 1;
        src_refill[i] = 1;
        src_data[i]   = FW'($urandom);
      end
    end
  endtask

  task automatic chk_hist(input string name, input int exp_q[$]);
    chk({name, "_count"}, hist.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < hist.size()) chk(name, hist[k], exp_q[k]);
      else chk(name, 32'hffff_ffff, exp_q[k]);
    end
  endtask

  initial begin
    logic [FW-1:0] held;
    int n;
    en     = '1;
    oready = 1'b1;
    for (int i = 0; i < N; i++) src_data[i] = FW'($urandom);
    reset_dut(2);
    chk("rst_out_valid", link.out_valid, 0);
    chk("rst_locked", link.locked, 0);
    chk("rst_grant_idx", link.grant_idx, 0);
    chk("rst_out_data", link.out_data, 0);

    // Round-robin rotation with single-flit packets.
    start_singles(4'b1111);
    repeat (5) cycle();
    chk_hist("rr_seq", '{0, 1, 2, 3, 0});

    // Packet lock: req1 sends three flits while the others keep requesting.
    reset_dut(1);
    src_len[1] = 3; src_data[1] = FW'($urandom);
    cycle();
    chk("lock_locked", link.locked, 1);
    start_singles(4'b1101);
    repeat (3) cycle();
    chk_hist("lock_seq", '{1, 1, 1, 2});
    chk("lock_released", link.locked, 0);

    // Backpressure: output held, nothing accepted, then drain and refill together.
    oready = 1'b0;
    cycle();
    held = link.out_data;
    repeat (4) cycle();
    chk("bp_hold", link.out_data, held);
    chk("bp_no_ready", link.req_ready, 0);
    oready = 1'b1;
    n = hist.size();
    cycle();
    chk("bp_refill", hist.size(), n + 1);
    chk("bp_no_bubble", link.out_valid, 1);

    // Enable mask: only 1 and 3 eligible.
    reset_dut(1);
    en = 4'b1010;
    start_singles(4'b1111);
    repeat (4) cycle();
    chk_hist("en_seq", '{1, 3, 1, 3});

    // Disabling the owner mid-packet does not break the packet.
    reset_dut(1);
    en = 4'b1010;
    src_len[1] = 3; src_data[1] = FW'($urandom);
    cycle();
    en = 4'b1000;
    start_singles(4'b1101);
    repeat (3) cycle();
    chk_hist("en_lock_seq", '{1, 1, 1, 3});
    en = '1;

    // Reset in the middle of a 4-flit packet from req2.
    reset_dut(1);
    src_len[2] = 4; src_data[2] = FW'($urandom);
    repeat (2) cycle();
    chk("rstmid_flits", hist.size(), 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    src_len[2] = 0;
    chk("rstmid_out_valid", link.out_valid, 0);
    chk("rstmid_locked", link.locked, 0);
    hist.delete();
    src_len[3] = 1; src_data[3] = FW'($urandom);
    cycle();
    chk_hist("rstmid_req3", '{3});
    chk("rstmid_grant_idx", link.grant_idx, 3);

    // Only req3 active: repeated grants, pointer wraps to 0 each time.
    reset_dut(1);
    start_singles(4'b1000);
    repeat (4) cycle();
    chk_hist("wrap_seq", '{3, 3, 3, 3});

    // Random traffic with variable packet lengths, enables and backpressure.
    reset_dut(1);
    for (int c = 0; c < 800; c++) begin
      if (c % 32 == 0) en = N'($urandom);
      oready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        if (src_len[i] == 0 && ($urandom % 4) == 0) begin
          src_len[i]  = $urandom_range(1, 4);
          src_data[i] = FW'($urandom);
        end
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/noc_port_arbiter.md
Name: noc_port_arbiter

Overview:
- Clocked output-port arbiter for one router output link of the 16-node NoC (two 8-node cubes joined by vertical links).
- Shares a single outgoing link between N_REQ requesters: the node's other input links plus the local injection port (dg).
- Round-robin grant; the grant is locked to the winner for every flit of a multi-flit packet until its tail flit is accepted.
- A one-entry output register decouples the arbitration decision from the downstream link.

Parameters:
- N_REQ, 4, number of requesters (3 neighbour inputs + local injection); legal range 2..8.
- FLIT_W, 11, flit data width (matches the 11-bit e1of2 link payload).
- IDX_W, 2, width of the grant index; must equal $clog2(N_REQ).

Ports:
- CLK  input  1  single system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester flit valid.
- req_data  input  N_REQ x FLIT_W  per-requester flit payload.
- req_tail  input  N_REQ  flit is the last of its packet; single-flit packets set tail=1.
- req_enable  input  N_REQ  per-requester arbitration enable (config).
- req_ready  output  N_REQ  flit accepted this cycle (combinational, one-hot or zero).
- out_valid  output  1  output register holds a flit.
- out_data  output  FLIT_W  registered flit.
- out_tail  output  1  registered tail flag.
- out_ready  input  1  downstream accepts the flit this cycle.
- grant_idx  output  IDX_W  current or most recent owner.
- locked  output  1  high while a packet is in progress (state LOCKED).

Behaviour:
- Reset (RESET=1 at a clock edge): out_valid=0, out_data=0, out_tail=0, state=ARB, rr_ptr=0, grant_idx=0, locked=0. req_ready is forced to 0 while RESET is high.
- RESET mid-packet: the packet is dropped, the lock is cleared and the output register is emptied on the next edge. There is no partial-packet recovery.
- slot_free = !out_valid || out_ready (the register drains and refills in the same cycle).
- Handshake rules:
  - Requester handshake = req_valid[i] && req_ready[i].
  - Downstream handshake = out_valid && out_ready.
  - Requesters must hold data stable while valid && !ready.
- State ARB:
  - Candidates = req_valid & req_enable.
  - Winner = first candidate searching from rr_ptr upward, wrapping modulo N_REQ (rr_ptr is itself highest priority).
  - If slot_free and a candidate exists: req_ready[winner]=1, the flit loads into the output register, grant_idx<=winner.
  - If the flit is a tail: stay in ARB, rr_ptr<=(winner+1) mod N_REQ.
  - If the flit is not a tail: go to LOCKED, owner=winner; rr_ptr is unchanged.
  - No candidate or !slot_free: nothing accepted, rr_ptr unchanged.
- State LOCKED:
  - Only the owner is eligible; req_ready[owner] = req_valid[owner] && slot_free.
  - req_enable[owner] is ignored, so a packet always completes.
  - Other requesters see req_ready=0.
  - Tail accepted: state<=ARB, rr_ptr<=(owner+1) mod N_REQ.
- Output register:
  - On a downstream handshake with no new load: out_valid<=0.
  - On a load: out_valid<=1, with data and tail updated together.
- Latency and throughput: 1 cycle from requester handshake to out_valid; throughput 1 flit/cycle with out_ready held high.
- Simultaneous events: drain and load in the same cycle is legal. All-requesters-valid rotates strictly in round-robin order. A request arriving exactly at rr_ptr wins.
- Wrap-around: rr_ptr moves from N_REQ-1 to 0.
- Backpressure: out_ready=0 holds out_valid, out_data and out_tail unchanged indefinitely.

Decomposition:
- noc_pkg holds:
  - FLIT_W=11, IP_W=4, NUM_NODES=16;
  - enum arb_state_t {ARB, LOCKED};
  - flit field positions (dest IP [10:7]).
- Sub-module rr_picker (combinational): inputs req mask and pointer; outputs one-hot grant, index and any. It is reused by the future VC allocator.

Test Plan:
- Round-robin rotation: all 4 requesters valid with single-flit packets, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one flit/cycle, each out_data matching its source.
- Packet lock: req1 sends a 3-flit packet (tail on the 3rd flit) while req0/2/3 are continuously valid -> out shows req1's three flits back-to-back, then req2 wins (rr_ptr=2).
- Backpressure: out_ready=0 for 5 cycles with a flit loaded -> out_data stable, all req_ready=0. out_ready=1 -> drain and refill in the same cycle, no bubble.
- Enable mask: req_enable=4'b1010 with all requesters valid -> only 1 and 3 alternate. Clearing enable[1] mid-packet of req1 still completes the packet.
- Reset mid-packet: RESET after flit 2 of 4 from req2 -> next cycle out_valid=0, locked=0, rr_ptr=0. A subsequent req3 single flit is granted immediately.
- Idle/wrap: only req3 valid repeatedly -> continuous grants to 3, rr_ptr wrapping to 0 after each; no spurious req_ready on idle requesters.
